branch_predict_unit: RTL
========================

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- PC_W, 9, PC width in bits; SHALL satisfy PC_W > IDX_W+2.
- ENTRIES, 16, predictor table depth; power of two, at least 2.
- IDX_W, $clog2(ENTRIES), derived index width.
- TAG_W, PC_W-IDX_W-2, derived tag width.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on rising edge.
- reset, in, 1, asynchronous, active-high reset.
- F_PC, in, PC_W, fetch-stage PC to predict.
- Pred_Taken, out, 1, fetch prediction: taken.
- Pred_PC, out, 32, predicted next fetch PC.
- Ex_Valid, in, 1, execute-stage instruction valid.
- Ex_Branch, in, 1, execute instruction is a conditional branch.
- Ex_PC, in, PC_W, execute-stage instruction PC.
- Imm, in, 32, branch immediate (halfword offset).
- AluResult, in, 32, comparison result; branch condition true iff equal to 1.
- Ex_Pred_Taken, in, 1, prediction that travelled with the execute instruction.
- Ex_Pred_PC, in, 32, predicted PC that travelled with the execute instruction.
- PC_Imm, out, 32, branch target.
- PC_Four, out, 32, fall-through PC.
- BrPC, out, 32, redirect PC.
- PcSel, out, 1, redirect/flush request.
- Br_Count, out, 32, resolved branch count.
- Mis_Count, out, 32, mispredict count.

Function
REQ-003 The table SHALL hold, per entry: valid bit, TAG_W tag, 32-bit target and 2-bit saturating counter.
REQ-004 Fetch index SHALL be F_PC[IDX_W+1:2]; tag SHALL be F_PC[PC_W-1:IDX_W+2]. Execute index and tag SHALL use the same bit fields of Ex_PC.
REQ-005 Lookup SHALL be combinational: hit = valid && tag match; Pred_Taken = hit && counter[1].
REQ-006 Pred_PC SHALL be the stored target when Pred_Taken is 1, else zero-extended F_PC + 4.
REQ-007 PC_Imm SHALL be zero-extended Ex_PC + (Imm << 1), modulo 2^32.
REQ-008 PC_Four SHALL be zero-extended Ex_PC + 4, modulo 2^32.
REQ-009 Actual taken (AT) SHALL be Ex_Valid && Ex_Branch && AluResult == 32'd1.
REQ-010 A mispredict SHALL be flagged when Ex_Valid && Ex_Branch && (AT != Ex_Pred_Taken || (AT && Ex_Pred_PC != PC_Imm)).
REQ-011 A mispredict SHALL also be flagged when Ex_Valid && !Ex_Branch && Ex_Pred_Taken.
REQ-012 PcSel SHALL equal the mispredict flag, combinationally, in the resolve cycle.
REQ-013 BrPC SHALL be PC_Imm when PcSel && AT, PC_Four when PcSel && !AT, and 0 otherwise.
REQ-014 On a rising edge with Ex_Valid && Ex_Branch and an execute hit, the counter SHALL update by one step:
- AT = 1: increment, saturating at 11.
- AT = 0: decrement, saturating at 00.
- AT = 1: target SHALL also be written with PC_Imm.
REQ-015 On Ex_Valid && Ex_Branch && AT with an execute miss, the entry SHALL be allocated: valid = 1, tag and target written, counter = 10.
REQ-016 A not-taken miss SHALL NOT allocate an entry.
REQ-017 On Ex_Valid && !Ex_Branch && Ex_Pred_Taken with an execute hit, the entry SHALL be invalidated (alias removal).
REQ-018 When fetch and execute use the same index in one cycle, the lookup SHALL return the pre-update contents; the update SHALL be visible the next cycle.
REQ-019 Br_Count SHALL increment on every edge with Ex_Valid && Ex_Branch, saturating at 32'hFFFFFFFF.
REQ-020 Mis_Count SHALL increment on every edge with PcSel = 1, saturating at 32'hFFFFFFFF.
REQ-021 With Ex_Valid = 0: no table or counter update, and PcSel = 0.

Reset
REQ-022 reset SHALL act asynchronously: all valid bits = 0, counters = 01, targets and tags = 0, Br_Count = Mis_Count = 0.
REQ-023 While reset is high: Pred_Taken = 0, and Pred_PC = F_PC + 4.
REQ-024 Reset asserted mid-operation SHALL discard any pending update in that cycle.
REQ-025 Deassertion SHALL take effect at the first rising edge after reset falls.

Verification
REQ-026 Post-reset, F_PC = 0x040 -> Pred_Taken = 0, Pred_PC = 0x044, counts 0.
REQ-027 Branch with Ex_PC = 0x040, Imm = 8, AluResult = 1, Ex_Pred_Taken = 0:
- Same cycle: PcSel = 1, BrPC = 0x050.
- Next cycle, F_PC = 0x040: Pred_Taken = 1, Pred_PC = 0x050.
- Br_Count = 1, Mis_Count = 1.
REQ-028 Three more resolutions of the same branch with AluResult = 1 and correct prediction -> PcSel = 0, counter = 11 (saturated).
- Two not-taken resolutions then follow -> counter = 01, Pred_Taken = 0.
- Each not-taken resolution predicted taken -> BrPC = 0x044.
REQ-029 Non-branch at 0x040 with Ex_Pred_Taken = 1 -> PcSel = 1, BrPC = 0x044; entry invalidated next cycle.
REQ-030 Fetch and resolve at the same index in one cycle -> old prediction that cycle, new prediction next cycle.
- reset pulsed mid-cycle -> outputs return to reset values immediately, without a clock edge.

Source files
------------

// File: rtl/branch_predict_unit.sv
// branch_predict_unit
// Direct-mapped branch target buffer with 2-bit saturating counters, plus the
// execute-stage branch resolution that checks the fetch-time prediction.
//
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   F_PC                - fetch PC to look up
//   Pred_Taken, Pred_PC - fetch prediction (combinational lookup)
//   Ex_Valid, Ex_Branch - execute instruction valid / is a conditional branch
//   Ex_PC, Imm          - execute PC and halfword branch offset
//   AluResult           - branch condition (taken iff == 1)
//   Ex_Pred_Taken/PC    - prediction that travelled with the execute instr
//   PC_Imm, PC_Four     - branch target / fall-through PC
//   BrPC, PcSel         - redirect PC and redirect/flush request
//   Br_Count, Mis_Count - saturating resolved-branch / mispredict counters
module branch_predict_unit #(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = PC_W - IDX_W - 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] F_PC,
  output logic            Pred_Taken,
  output logic [31:0]     Pred_PC,
  input  logic            Ex_Valid,
  input  logic            Ex_Branch,
  input  logic [PC_W-1:0] Ex_PC,
  input  logic [31:0]     Imm,
  input  logic [31:0]     AluResult,
  input  logic            Ex_Pred_Taken,
  input  logic [31:0]     Ex_Pred_PC,
  output logic [31:0]     PC_Imm,
  output logic [31:0]     PC_Four,
  output logic [31:0]     BrPC,
  output logic            PcSel,
  output logic [31:0]     Br_Count,
  output logic [31:0]     Mis_Count
);

  localparam int PAD_W = 32 - PC_W;

  // One step of a 2-bit saturating counter.
  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? 2'b11 : c + 2'b01;
    else    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  // 32-bit event counter that sticks at all-ones.
  function automatic logic [31:0] count_sat(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  logic [ENTRIES-1:0]            valid_q;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_q;
  logic [ENTRIES-1:0][31:0]      target_q;
  logic [ENTRIES-1:0][1:0]       ctr_q;
  logic [31:0]                   br_count_q;
  logic [31:0]                   mis_count_q;

  logic [IDX_W-1:0] f_idx, ex_idx;
  logic [TAG_W-1:0] f_tag, ex_tag;
  logic             f_hit, ex_hit;
  logic [31:0]      f_pc_ext, ex_pc_ext;
  logic             act_taken;
  logic             ex_br;
  logic             mispredict;

  assign f_idx  = F_PC[IDX_W+1:2];
  assign f_tag  = F_PC[PC_W-1:IDX_W+2];
  assign ex_idx = Ex_PC[IDX_W+1:2];
  assign ex_tag = Ex_PC[PC_W-1:IDX_W+2];

  assign f_pc_ext  = {{PAD_W{1'b0}}, F_PC};
  assign ex_pc_ext = {{PAD_W{1'b0}}, Ex_PC};

  // Fetch lookup reads the registered table, so a same-index update in this
  // cycle only becomes visible after the edge.
  assign f_hit      = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign Pred_Taken = !reset && f_hit && ctr_q[f_idx][1];
  assign Pred_PC    = Pred_Taken ? target_q[f_idx] : f_pc_ext + 32'd4;

  // Execute resolution
  assign ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign PC_Imm    = ex_pc_ext + (Imm << 1);
  assign PC_Four   = ex_pc_ext + 32'd4;
  assign ex_br     = Ex_Valid && Ex_Branch;
  assign act_taken = ex_br && (AluResult == 32'd1);

  // A taken prediction on a non-branch means the BTB aliased onto it.
  assign mispredict = (ex_br && ((act_taken != Ex_Pred_Taken) ||
                                 (act_taken && (Ex_Pred_PC != PC_Imm)))) ||
                      (Ex_Valid && !Ex_Branch && Ex_Pred_Taken);

  assign PcSel = mispredict;
  assign BrPC  = !mispredict ? 32'd0 : (act_taken ? PC_Imm : PC_Four);

  assign Br_Count  = br_count_q;
  assign Mis_Count = mis_count_q;

  // Table and counter update at the resolve edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= '0;
      tag_q       <= '0;
      target_q    <= '0;
      ctr_q       <= {ENTRIES{2'b01}};
      br_count_q  <= '0;
      mis_count_q <= '0;
    end else begin
      if (ex_br) begin
        br_count_q <= count_sat(br_count_q);
        if (ex_hit) begin
          ctr_q[ex_idx] <= ctr_step(ctr_q[ex_idx], act_taken);
          if (act_taken) target_q[ex_idx] <= PC_Imm;
        end else if (act_taken) begin
          valid_q[ex_idx]  <= 1'b1;
          tag_q[ex_idx]    <= ex_tag;
          target_q[ex_idx] <= PC_Imm;
          ctr_q[ex_idx]    <= 2'b10;
        end
      end else if (Ex_Valid && Ex_Pred_Taken && ex_hit) begin
        valid_q[ex_idx] <= 1'b0;
      end
      if (mispredict) mis_count_q <= count_sat(mis_count_q);
    end
  end

endmodule
